// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution read path.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} conv_rd_state_t;

  localparam int IN_W   = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 18;

endpackage

// File: rtl/conv_mac.sv
// Signed 8x8 multiply with sign-extended 18-bit accumulation; clear wins over en.
module conv_mac
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_reg;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // sum already includes the current product so the final tap can be captured in the same cycle
  assign sum      = acc_reg + (en ? prod_ext : '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/conv_read_control.sv
// Sequences x/f memory reads, accumulates each window and streams the results out.
module conv_read_control
  import conv_pkg::*;
#(
  parameter int XSIZE    = 8,
  parameter int FSIZE    = 4,
  parameter int XLOGSIZE = 3,
  parameter int FLOGSIZE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [XLOGSIZE-1:0]     m_addr_x,
  output logic [FLOGSIZE-1:0]     m_addr_f,
  input  logic signed [IN_W-1:0]  m_data_x,
  input  logic signed [IN_W-1:0]  m_data_f,
  output logic                    rd_active,
  output logic signed [ACC_W-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  output logic                    conv_done
);

  localparam int NOUT = XSIZE - FSIZE + 1;
  localparam int CW   = $clog2(FSIZE + 1);
  localparam int NW   = $clog2(NOUT + 1);

  conv_rd_state_t          state_reg, state_next;
  logic [NW-1:0]           n_reg, n_next;
  logic [CW-1:0]           c_reg, c_next;
  logic signed [ACC_W-1:0] y_reg, y_next;
  logic signed [ACC_W-1:0] mac_sum;
  logic                    mac_en, mac_clear;
  logic                    addr_phase;

  conv_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (m_data_x),
    .b     (m_data_f),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      c_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      c_reg     <= c_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    c_next     = c_reg;
    y_next     = y_reg;
    mac_en     = 1'b0;
    mac_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = READ;
          n_next     = '0;
          c_next     = '0;
        end
      end
      READ: begin
        // data arriving at cycle c belongs to the address issued at c-1
        mac_en = (c_reg != '0);
        if (c_reg == CW'(FSIZE)) begin
          y_next     = mac_sum;
          mac_clear  = 1'b1;
          state_next = HOLD;
        end else begin
          c_next = c_reg + CW'(1);
        end
      end
      HOLD: begin
        if (m_ready_y) begin
          if (n_reg == NW'(NOUT - 1)) begin
            state_next = DONE;
          end else begin
            n_next     = n_reg + NW'(1);
            c_next     = '0;
            state_next = READ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr_phase   = (state_reg == READ) && (c_reg < CW'(FSIZE));
  assign m_addr_x     = addr_phase ? (XLOGSIZE'(n_reg) + XLOGSIZE'(c_reg)) : '0;
  assign m_addr_f     = addr_phase ? FLOGSIZE'(c_reg) : '0;
  assign rd_active    = (state_reg == READ) || (state_reg == HOLD);
  assign m_valid_y    = (state_reg == HOLD);
  assign conv_done    = (state_reg == DONE);
  assign m_data_out_y = y_reg;

endmodule

// File: tb/tb_conv_read_control.sv
// Self-checking bench: table-driven runs plus backpressure, reset and start-masking sequences.
module tb_conv_read_control;

  logic clk = 1'b0;
  logic reset, start, m_ready_y;
  logic [2:0] m_addr_x;
  logic [1:0] m_addr_f;
  logic signed [7:0] m_data_x, m_data_f;
  logic rd_active, m_valid_y, conv_done;
  logic signed [17:0] m_data_out_y;

  conv_read_control dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .m_addr_x     (m_addr_x),
    .m_addr_f     (m_addr_f),
    .m_data_x     (m_data_x),
    .m_data_f     (m_data_f),
    .rd_active    (rd_active),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y),
    .conv_done    (conv_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model with one-cycle registered read
  logic signed [7:0] x_mem [8];
  logic signed [7:0] f_mem [4];
  always @(posedge clk) begin
    m_data_x <= x_mem[m_addr_x];
    m_data_f <= f_mem[m_addr_f];
  end

  typedef struct { int y; int cyc; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0][7:0]  x;
    logic [3:0][7:0]  f;
    logic [4:0][17:0] y;
  } vec_t;
  vec_t vec [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every transfer pops one expected result
  logic prev_stall = 1'b0;
  logic signed [17:0] prev_y = '0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      check("hold_valid", m_valid_y, 1);
      check("hold_data", m_data_out_y, prev_y);
    end
    if (m_valid_y && m_ready_y) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %0d with empty scoreboard (cycle %0d)", m_data_out_y, cyc);
      end else begin
        e = sb_q.pop_front();
        check("y_data", m_data_out_y, e.y);
        if (e.cyc >= 0) check("y_cycle", cyc, e.cyc);
      end
    end
    prev_stall <= m_valid_y && !m_ready_y;
    prev_y     <= m_data_out_y;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int i);
    for (int k = 0; k < 8; k++) x_mem[k] = vec[i].x[k];
    for (int k = 0; k < 4; k++) f_mem[k] = vec[i].f[k];
  endtask

  task automatic push_run(int i, int first_cyc, int period);
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      e.y   = $signed(vec[i].y[k]);
      e.cyc = first_cyc + period * k;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(int limit, output int dcyc);
    dcyc = -1;
    for (int t = 0; t < limit; t++) begin
      tick();
      if (conv_done) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_valid"}, m_valid_y, 0);
    check({tag, "_done"}, conv_done, 0);
    check({tag, "_rd_active"}, rd_active, 0);
    check({tag, "_addr_x"}, m_addr_x, 0);
    check({tag, "_addr_f"}, m_addr_f, 0);
    check({tag, "_y"}, m_data_out_y, 0);
  endtask

  // one full run at ready=1; vector 0 also checks the address/rd_active trace every cycle
  task automatic run_vector(int i);
    int s, d, n, c, ex, ef, ra;
    load(i);
    tick();
    start = 1'b1;
    s = cyc;
    push_run(i, s + 6, 6);
    d = -1;
    for (int o = 1; o <= 40 && d < 0; o++) begin
      tick();
      start = 1'b0;
      if (i == 0 && o <= 31) begin
        n  = (o - 1) / 6;
        c  = (o - 1) % 6;
        ex = (o <= 30 && c < 4) ? n + c : 0;
        ef = (o <= 30 && c < 4) ? c : 0;
        ra = (o <= 30) ? 1 : 0;
        check("addr_x", m_addr_x, ex);
        check("addr_f", m_addr_f, ef);
        check("rd_active", rd_active, ra);
      end
      if (conv_done) d = o;
    end
    check("done_offset", d, 31);
  endtask

  initial begin
    int s, d;
    int x3 [8] = '{3, -2, 5, 0, -7, 1, 4, -1};
    int f3 [4] = '{2, -1, 0, 3};
    int y0 [5] = '{10, 14, 18, 22, 26};
    int y3 [5] = '{8, -30, 13, 19, -18};

    for (int k = 0; k < 8; k++) begin
      vec[0].x[k] = 8'(k + 1);
      vec[1].x[k] = 8'(-128);
      vec[2].x[k] = 8'(127);
      vec[3].x[k] = 8'(x3[k]);
    end
    for (int k = 0; k < 4; k++) begin
      vec[0].f[k] = 8'(1);
      vec[1].f[k] = 8'(-128);
      vec[2].f[k] = 8'(-128);
      vec[3].f[k] = 8'(f3[k]);
    end
    for (int k = 0; k < 5; k++) begin
      vec[0].y[k] = 18'(y0[k]);
      vec[1].y[k] = 18'(65536);
      vec[2].y[k] = 18'(-65024);
      vec[3].y[k] = 18'(y3[k]);
    end
    for (int k = 0; k < 8; k++) x_mem[k] = '0;
    for (int k = 0; k < 4; k++) f_mem[k] = '0;

    reset = 1'b1;
    start = 1'b0;
    m_ready_y = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vector(i);

    // backpressure: ready low for cycles 6..8, transfer in cycle 9
    load(0);
    m_ready_y = 1'b0;
    tick();
    start = 1'b1;
    s = cyc;
    push_run(0, s + 9, 6);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("bp_early_valid", m_valid_y, 0);
    for (int o = 6; o <= 8; o++) begin
      tick();
      check("bp_valid", m_valid_y, 1);
      check("bp_data", m_data_out_y, 10);
    end
    tick();
    m_ready_y = 1'b1;
    wait_done(60, d);
    check("bp_done_cycle", d, s + 34);

    // reset during the second READ discards the run
    load(0);
    tick();
    start = 1'b1;
    s = cyc;
    push_run(0, s + 6, 6);
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("mid_rd_active", rd_active, 1);
    reset = 1'b1;
    tick();
    check_idle_outputs("midreset");
    sb_q.delete();
    reset = 1'b0;
    run_vector(0);

    // start pulses in READ/HOLD are ignored; start held through DONE restarts at once
    load(3);
    tick();
    start = 1'b1;
    s = cyc;
    push_run(3, s + 6, 6);
    push_run(3, s + 38, 6);
    for (int o = 1; o <= 64; o++) begin
      tick();
      start = (o == 3 || o == 6 || (o >= 30 && o <= 32));
      if (o == 31) check("si_done1", conv_done, 1);
      if (o == 32) check("si_idle_rd_active", rd_active, 0);
      if (o == 33) check("si_restart_rd_active", rd_active, 1);
      if (o == 63) check("si_done2", conv_done, 1);
    end
    start = 1'b0;
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_read_control.md
# conv_read_control

Read-side controller for the 8-tap-input / 4-tap-filter convolution datapath. Once the write controllers have filled the x and f memories, it sequences reads, multiply-accumulates each window and presents every result on the `m_*_y` valid/ready output stream. After the last output is accepted it pulses `conv_done`, which hands both memories back to the write controllers.

## Interface
- `XSIZE`, 8: number of x samples in memory.
- `FSIZE`, 4: number of filter taps.
- `XLOGSIZE`, 3: x address width.
- `FLOGSIZE`, 2: f address width.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: both memories loaded; sampled only in IDLE.
- `m_addr_x` output XLOGSIZE: x memory read address.
- `m_addr_f` output FLOGSIZE: f memory read address.
- `m_data_x` input signed 8: x memory read data; 1-cycle registered read latency.
- `m_data_f` input signed 8: f memory read data; 1-cycle registered read latency.
- `rd_active` output 1: high while this block owns the memory address ports; top-level mux select.
- `m_data_out_y` output signed 18: convolution result.
- `m_valid_y` output 1: result valid.
- `m_ready_y` input 1: downstream ready.
- `conv_done` output 1: one-cycle pulse after the final result transfers.

## Operation
- NOUT = XSIZE − FSIZE + 1 = 5 outputs per run.
- y[n] = Σ_{k=0..FSIZE−1} x[n+k]·f[k].
- Products are signed 16-bit and sign-extended to 18 bits. Accumulation is 18-bit signed, with no saturation. The worst case of 4·(−128·−128)=65536 fits.
- States:
  - IDLE: `start`=1 → READ, with n=0, c=0, acc=0.
  - READ: runs FSIZE+1 cycles, c=0..FSIZE.
    - For c<FSIZE: drive `m_addr_x`=n+c and `m_addr_f`=c.
    - For c≥1: add `m_data_x`·`m_data_f`, which is the data for address c−1.
    - At c=FSIZE: register acc+product into `m_data_out_y`, clear acc, go to HOLD.
  - HOLD: `m_valid_y`=1 and `m_data_out_y` is held stable.
    - On `m_valid_y`&&`m_ready_y` with n<NOUT−1: n++, c=0, go to READ.
    - On transfer with n=NOUT−1: go to DONE.
  - DONE: `conv_done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE.
- A `start` held high across DONE→IDLE begins a new run on the next IDLE cycle.
- Outside READ, `m_addr_x`/`m_addr_f` = 0.
- `rd_active`=1 in READ and HOLD, 0 otherwise.
- Reset (any state, including mid-READ or HOLD):
  - state → IDLE; n, c and acc cleared.
  - `m_valid_y`=0, `m_data_out_y`=0, `conv_done`=0, `rd_active`=0, addresses 0.
  - A result pending in HOLD is discarded.

## Timing
- `start` high in cycle 0 → READ cycles 1..FSIZE+1 → first `m_valid_y` in cycle FSIZE+2 (cycle 6 at defaults).
- Output period with `m_ready_y` held high is FSIZE+2 = 6 cycles. There is no read/hold overlap.
- With `m_ready_y`=0, `m_valid_y` and data hold indefinitely. `m_valid_y` never drops without a transfer, except on reset.
- `conv_done` is high in the cycle after the fifth transfer.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `conv_pkg`:
  - state enum `conv_rd_state_t` {IDLE, READ, HOLD, DONE};
  - constants `IN_W`=8, `PROD_W`=16, `ACC_W`=18.
- Sub-module `conv_mac`:
  - signed 8×8 multiply, sign-extend, 18-bit accumulate;
  - `clear` and `en` inputs.
- The FSM, counters n and c, and the output register live in `conv_read_control`.

## Test plan
- Basic run: x=1..8, f={1,1,1,1}, `m_ready_y`=1.
  - Outputs are 10, 14, 18, 22, 26, at cycles 6, 12, 18, 24, 30.
  - `conv_done` is high in cycle 31.
- Signed extremes:
  - x all −128, f all −128 → five outputs of 65536.
  - x all 127, f all −128 → five outputs of −65024.
- Backpressure: `m_ready_y`=0 for 3 cycles after the first valid, using the basic-run data.
  - `m_data_out_y` stays 10 and `m_valid_y` stays 1 for those cycles.
  - Transfer occurs when ready rises; the next output is 14 six cycles later.
- Address sequence for n=2: `m_addr_x` = 2, 3, 4, 5 and `m_addr_f` = 0, 1, 2, 3 on READ cycles c=0..3. Both addresses are 0 otherwise.
- Reset mid-operation: assert `reset` during the second READ.
  - Next cycle: all outputs 0 and state IDLE.
  - A subsequent `start` reproduces the basic-run results from y=10.
- `start` pulsed during HOLD and READ has no effect.
  - A `start` held high through DONE restarts in the first IDLE cycle.
